// File: rtl/adc_scan_ctrl.sv
// adc_scan_ctrl: multi-channel SPI scan master for MCP3204/3208-class ADCs.
// Scans the enabled channel mask in single-ended or pseudo-differential mode.
// Each DATA_W-bit result is delivered with its channel index on a valid/ready
// handshake. A sticky overrun flag records a result overwritten while unconsumed.
// Optional build macro ADC_RESULT_BANK_EN adds a per-channel result bank with a
// combinational read port (rd_ch / rd_data).
module adc_scan_ctrl #(
  parameter int CLK_DIV = 500,
  parameter int NUM_CH  = 4,
  parameter int DATA_W  = 12
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              cont,
  input  logic              diff,
  input  logic [NUM_CH-1:0] chan_en,
  output logic              busy,
  output logic [DATA_W-1:0] out_data,
  output logic [2:0]        out_ch,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              overrun,
  output logic              CS,
  output logic              P3,
  input  logic              P4,
  output logic              P5
`ifdef ADC_RESULT_BANK_EN
  ,
  input  logic [2:0]        rd_ch,
  output logic [DATA_W-1:0] rd_data
`endif
);

  localparam int DIV_W    = (CLK_DIV > 2) ? $clog2(CLK_DIV) : 1;
  localparam int LAST_CAP = (DATA_W < 12) ? (6 + DATA_W) : 18;

  typedef enum logic [1:0] {IDLE, CS_HIGH, SHIFT, DONE} state_t;

  // Lowest enabled index >= lo; bit 3 flags that one was found.
  function automatic logic [3:0] find_ch(input logic [NUM_CH-1:0] mask, input logic [3:0] lo);
    logic [3:0] r;
    r = 4'd0;
    for (int i = NUM_CH - 1; i >= 0; i--) begin
      r = (mask[i] && (4'(i) >= lo)) ? {1'b1, 3'(i)} : r;
    end
    return r;
  endfunction

  // Command bit driven on DIN for a given slot: start, SGL/DIFF, D2..D0, then zeros.
  function automatic logic cmd_bit(input logic [4:0] slot, input logic d, input logic [2:0] c);
    case (slot)
      5'd0:    return 1'b1;
      5'd1:    return ~d;
      5'd2:    return c[2];
      5'd3:    return c[1];
      5'd4:    return c[0];
      default: return 1'b0;
    endcase
  endfunction

  state_t              state_r, state_nxt;
  logic [DIV_W-1:0]    div_cnt_r, div_nxt;
  logic [4:0]          slot_r, slot_nxt;
  logic [NUM_CH-1:0]   en_r;
  logic                diff_r;
  logic [2:0]          ch_r;
  logic [DATA_W-1:0]   shreg_r;
  logic                busy_r, valid_r, ovr_r, cs_r, sclk_r, mosi_r;
  logic [DATA_W-1:0]   out_data_r;
  logic [2:0]          out_ch_r;
  logic [3:0]          above_s, first_s, start_ch_s;
  logic                div_last_s, accept_s;

  assign above_s    = find_ch(en_r, {1'b0, ch_r} + 4'd1);
  assign first_s    = find_ch(en_r, 4'd0);
  assign start_ch_s = find_ch(chan_en, 4'd0);
  assign div_last_s = (div_cnt_r == DIV_W'(CLK_DIV - 1));
  assign accept_s   = (state_r == IDLE) && start && (|chan_en);

  // Next-state, divider and slot sequencing.
  always_comb begin
    state_nxt = state_r;
    div_nxt   = div_last_s ? '0 : div_cnt_r + DIV_W'(1);
    slot_nxt  = slot_r;
    case (state_r)
      IDLE: begin
        div_nxt   = '0;
        slot_nxt  = 5'd0;
        state_nxt = accept_s ? CS_HIGH : IDLE;
      end
      CS_HIGH: begin
        slot_nxt  = 5'd0;
        state_nxt = div_last_s ? SHIFT : CS_HIGH;
      end
      SHIFT: begin
        if (div_last_s && (slot_r == 5'd18)) begin
          state_nxt = DONE;
          slot_nxt  = 5'd0;
        end else if (div_last_s) begin
          slot_nxt  = slot_r + 5'd1;
        end else begin
          slot_nxt  = slot_r;
        end
      end
      DONE: begin
        div_nxt   = '0;
        state_nxt = (above_s[3] || cont) ? CS_HIGH : IDLE;
      end
      default: begin
        div_nxt   = '0;
        state_nxt = IDLE;
      end
    endcase
  end

  // Sequencer state plus registered pin outputs derived from the next state.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r   <= IDLE;
      div_cnt_r <= '0;
      slot_r    <= 5'd0;
      cs_r      <= 1'b1;
      sclk_r    <= 1'b0;
      mosi_r    <= 1'b0;
    end else begin
      state_r   <= state_nxt;
      div_cnt_r <= div_nxt;
      slot_r    <= slot_nxt;
      cs_r      <= (state_nxt != SHIFT);
      sclk_r    <= (state_nxt == SHIFT) && (div_nxt >= DIV_W'(CLK_DIV / 2));
      mosi_r    <= (state_nxt == SHIFT) ? cmd_bit(slot_nxt, diff_r, ch_r) : 1'b0;
    end
  end

  // Scan context: latched mask/mode, current channel and busy flag.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      en_r   <= '0;
      diff_r <= 1'b0;
      ch_r   <= 3'd0;
      busy_r <= 1'b0;
    end else if (accept_s) begin
      en_r   <= chan_en;
      diff_r <= diff;
      ch_r   <= start_ch_s[2:0];
      busy_r <= 1'b1;
    end else if (state_r == DONE) begin
      ch_r   <= above_s[3] ? above_s[2:0] : first_s[2:0];
      busy_r <= above_s[3] | cont;
    end
  end

  // Capture DOUT on the SCLK rising point of the result slots, MSB first.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      shreg_r <= '0;
    end else if ((state_r == SHIFT) && (div_cnt_r == DIV_W'(CLK_DIV / 2)) &&
                 (slot_r >= 5'd7) && (slot_r <= 5'(LAST_CAP))) begin
      shreg_r <= {shreg_r[DATA_W-2:0], P4};
    end
  end

  // Result handshake: DONE reloads (and wins over a same-cycle consume).
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      out_data_r <= '0;
      out_ch_r   <= 3'd0;
      valid_r    <= 1'b0;
      ovr_r      <= 1'b0;
    end else if (state_r == DONE) begin
      out_data_r <= shreg_r;
      out_ch_r   <= ch_r;
      valid_r    <= 1'b1;
      ovr_r      <= ovr_r | (valid_r & ~out_ready);
    end else if (valid_r && out_ready) begin
      valid_r    <= 1'b0;
    end
  end

`ifdef ADC_RESULT_BANK_EN
  logic [DATA_W-1:0] bank_r [NUM_CH];

  // Per-channel result bank, written at every end of frame.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < NUM_CH; i++) bank_r[i] <= '0;
    end else begin
      for (int i = 0; i < NUM_CH; i++) begin
        if ((state_r == DONE) && (ch_r == 3'(i))) bank_r[i] <= shreg_r;
      end
    end
  end

  // Combinational bank read; out-of-range channels read as zero.
  always_comb begin
    rd_data = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      rd_data = (rd_ch == 3'(i)) ? bank_r[i] : rd_data;
    end
  end
`endif

  assign busy      = busy_r;
  assign out_data  = out_data_r;
  assign out_ch    = out_ch_r;
  assign out_valid = valid_r;
  assign overrun   = ovr_r;
  assign CS        = cs_r;
  assign P3        = sclk_r;
  assign P5        = mosi_r;

endmodule

// File: tb/tb_adc_scan_ctrl.sv
// Testbench for adc_scan_ctrl: ADC pin model, timer-based behavioural model,
// per-cycle compare process, directed literal tests and a randomized phase.
module tb_adc_scan_ctrl;
  localparam int C      = 4;
  localparam int NUM_CH = 4;
  localparam int DATA_W = 12;
  localparam int FRAME  = 20 * C + 1;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic start = 1'b0, cont = 1'b0, diff = 1'b0;
  logic [NUM_CH-1:0] chan_en = '0;
  logic out_ready = 1'b0;
  logic busy, out_valid, overrun, CS, P3, P5;
  logic P4 = 1'b0;
  logic [DATA_W-1:0] out_data;
  logic [2:0] out_ch;
`ifdef ADC_RESULT_BANK_EN
  logic [2:0] rd_ch = 3'd0;
  logic [DATA_W-1:0] rd_data;
`endif

  int vectors = 0;
  int miscompares = 0;
  int ready_mode = 1;          // 0: hold low, 1: hold high, 2: random
  logic [11:0] adc_val [8];
  logic [4:0]  cmd_q [$];
  logic [14:0] res_q [$];

  adc_scan_ctrl #(.CLK_DIV(C), .NUM_CH(NUM_CH), .DATA_W(DATA_W)) dut (
    .clk(clk), .rst(rst), .start(start), .cont(cont), .diff(diff),
    .chan_en(chan_en), .busy(busy), .out_data(out_data), .out_ch(out_ch),
    .out_valid(out_valid), .out_ready(out_ready), .overrun(overrun),
    .CS(CS), .P3(P3), .P4(P4), .P5(P5)
`ifdef ADC_RESULT_BANK_EN
    , .rd_ch(rd_ch), .rd_data(rd_data)
`endif
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model (timer per frame) ----------------
  bit m_busy = 0, m_valid = 0, m_ovr = 0, m_diff = 0;
  int m_timer = 0, m_ch = 0, m_och = 0;
  logic [DATA_W-1:0] m_data = '0;
  logic [NUM_CH-1:0] m_en = '0;

  function automatic int lowest_above(input logic [NUM_CH-1:0] mask, input int after);
    for (int i = after + 1; i < NUM_CH; i++) if (mask[i]) return i;
    return -1;
  endfunction

  always @(posedge clk) begin
    bit hs;
    int nxt;
    if (!rst) begin
      m_busy = 0; m_valid = 0; m_ovr = 0; m_timer = 0; m_data = '0; m_och = 0;
    end else begin
      hs = m_valid && out_ready;
      if (!m_busy) begin
        if (hs) m_valid = 0;
        if (start && chan_en != '0) begin
          m_busy = 1; m_en = chan_en; m_diff = diff;
          m_ch = lowest_above(chan_en, -1); m_timer = FRAME;
        end
      end else begin
        m_timer--;
        if (m_timer == 0) begin
          if (m_valid && !hs) m_ovr = 1;
          m_valid = 1;
          m_data  = DATA_W'(adc_val[m_ch] >> (12 - DATA_W));
          m_och   = m_ch;
          nxt = lowest_above(m_en, m_ch);
          if (nxt >= 0) begin m_ch = nxt; m_timer = FRAME; end
          else if (cont) begin m_ch = lowest_above(m_en, -1); m_timer = FRAME; end
          else m_busy = 0;
        end else if (hs) m_valid = 0;
      end
    end
  end

  // ---------------- compare process (every cycle, away from the edge) ----------------
  always @(negedge clk) begin
    bit shift;
    int p, s;
    logic e_p3, e_p5;
    if (rst === 1'b1) begin
      shift = m_busy && m_timer >= 2 && m_timer <= 19 * C + 1;
      p = 19 * C + 1 - m_timer;
      s = p / C;
      e_p3 = shift && ((p % C) >= C / 2);
      case (s)
        0: e_p5 = 1'b1;
        1: e_p5 = !m_diff;
        2: e_p5 = ((m_ch >> 2) & 1) != 0;
        3: e_p5 = ((m_ch >> 1) & 1) != 0;
        4: e_p5 = (m_ch & 1) != 0;
        default: e_p5 = 1'b0;
      endcase
      e_p5 = shift && e_p5;
      check("busy", {31'd0, busy}, {31'd0, m_busy});
      check("CS", {31'd0, CS}, {31'd0, !shift});
      check("P3", {31'd0, P3}, {31'd0, e_p3});
      check("P5", {31'd0, P5}, {31'd0, e_p5});
      check("out_valid", {31'd0, out_valid}, {31'd0, m_valid});
      check("overrun", {31'd0, overrun}, {31'd0, m_ovr});
      if (m_valid) begin
        check("out_data", 32'(out_data), 32'(m_data));
        check("out_ch", 32'(out_ch), 32'(m_och));
      end
      if (out_valid === 1'b1 && out_ready === 1'b1) res_q.push_back({out_ch, out_data});
    end
  end

  // ---------------- ADC pin model ----------------
  int adc_slot = 0;
  logic [4:0] adc_cmd = '0;
  logic [2:0] adc_ch = '0;
  bit p3_prev = 0;
  always @(CS or P3) begin
    logic [11:0] v;
    if (CS !== 1'b0) begin
      adc_slot = 0; p3_prev = 0; P4 = 1'b0;
    end else if (P3 === 1'b1 && !p3_prev) begin
      p3_prev = 1;
      if (adc_slot < 5) adc_cmd = {adc_cmd[3:0], P5};
      if (adc_slot == 4) begin
        adc_ch = adc_cmd[2:0];
        cmd_q.push_back(adc_cmd);
        check("cmd_start", {31'd0, adc_cmd[4]}, 32'd1);
        check("cmd_sgl", {31'd0, adc_cmd[3]}, {31'd0, !m_diff});
        check("cmd_ch", 32'(adc_cmd[2:0]), 32'(m_ch));
      end
    end else if (P3 === 1'b0 && p3_prev) begin
      p3_prev = 0;
      adc_slot++;
      v = adc_val[adc_ch];
      P4 = (adc_slot >= 7 && adc_slot <= 18) ? v[18 - adc_slot] : 1'b0;
    end
  end

  // out_ready driver
  always @(posedge clk) begin
    #1;
    case (ready_mode)
      0: out_ready = 1'b0;
      1: out_ready = 1'b1;
      default: out_ready = 1'($urandom_range(0, 1));
    endcase
  end

  task automatic cycles(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic pulse_start(input logic [NUM_CH-1:0] en, input logic d);
    chan_en = en; diff = d; start = 1'b1;
    cycles(1);
    start = 1'b0;
  endtask

  task automatic wait_idle(input int bound, input string tag);
    int n = 0;
    while (busy !== 1'b0 && n < bound) begin cycles(1); n++; end
    if (busy !== 1'b0) check(tag, {31'd0, busy}, 32'd0);
  endtask

  initial begin
    int n, cs_low;
    for (int i = 0; i < 8; i++) adc_val[i] = 12'(i * 12'h111);
    // reset values
    cycles(3);
    check("rst_CS", {31'd0, CS}, 32'd1);
    check("rst_P3", {31'd0, P3}, 32'd0);
    check("rst_P5", {31'd0, P5}, 32'd0);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_valid", {31'd0, out_valid}, 32'd0);
    check("rst_ovr", {31'd0, overrun}, 32'd0);
    check("rst_data", 32'(out_data), 32'd0);
    check("rst_ch", 32'(out_ch), 32'd0);
    rst = 1'b1;
    cycles(3);

    // Test 1: single channel, fixed latency and frame shape
    adc_val[0] = 12'hA5C; ready_mode = 1; cmd_q.delete(); res_q.delete();
    chan_en = 4'b0001; diff = 1'b0; start = 1'b1;
    cycles(1);
    start = 1'b0; n = 1; cs_low = 0;
    while (out_valid !== 1'b1 && n < 200) begin
      if (CS === 1'b0) cs_low++;
      cycles(1); n++;
    end
    check("t1_latency", 32'(n), 32'd82);
    check("t1_cs_low", 32'(cs_low), 32'd76);
    check("t1_data", 32'(out_data), 32'h0A5C);
    check("t1_ch", 32'(out_ch), 32'd0);
    check("t1_busy_fell", {31'd0, busy}, 32'd0);
    check("t1_cmd", (cmd_q.size() == 1) ? 32'(cmd_q[0]) : 32'hDEAD, 32'b11000);

    // Test 2: differential, two channels, single shot
    cycles(5); cmd_q.delete(); res_q.delete();
    adc_val[1] = 12'h3C1; adc_val[3] = 12'hE07;
    pulse_start(4'b1010, 1'b1);
    wait_idle(400, "t2_timeout");
    cycles(3);
    check("t2_nres", 32'(res_q.size()), 32'd2);
    check("t2_cmd0", (cmd_q.size() > 0) ? 32'(cmd_q[0]) : 32'hDEAD, 32'b10001);
    check("t2_cmd1", (cmd_q.size() > 1) ? 32'(cmd_q[1]) : 32'hDEAD, 32'b10011);
    check("t2_res0", (res_q.size() > 0) ? 32'(res_q[0]) : 32'hDEAD, 32'({3'd1, 12'h3C1}));
    check("t2_res1", (res_q.size() > 1) ? 32'(res_q[1]) : 32'hDEAD, 32'({3'd3, 12'hE07}));

    // Test 3: continuous scan with stalled consumer -> overrun, wrap to ch0
    cmd_q.delete(); ready_mode = 0; cont = 1'b1;
    adc_val[0] = 12'h123; adc_val[2] = 12'h456;
    pulse_start(4'b0101, 1'b0);
    n = 0;
    while (overrun !== 1'b1 && n < 400) begin cycles(1); n++; end
    check("t3_overrun", {31'd0, overrun}, 32'd1);
    check("t3_ch", 32'(out_ch), 32'd2);
    check("t3_data", 32'(out_data), 32'h456);
    n = 0;
    while (cmd_q.size() < 3 && n < 200) begin cycles(1); n++; end
    check("t3_wrap", (cmd_q.size() > 2) ? 32'(cmd_q[2]) : 32'hDEAD, 32'b11000);
    cont = 1'b0;
    wait_idle(400, "t3_timeout");
    ready_mode = 1;
    cycles(3);

    // Test 4: asynchronous reset in slot 10
    pulse_start(4'b0001, 1'b0);
    n = 0;
    while (adc_slot != 10 && n < 200) begin cycles(1); n++; end
    check("t4_reached_slot10", 32'(adc_slot), 32'd10);
    @(posedge clk); #2;
    rst = 1'b0;
    #1;
    check("t4_CS", {31'd0, CS}, 32'd1);
    check("t4_P3", {31'd0, P3}, 32'd0);
    check("t4_P5", {31'd0, P5}, 32'd0);
    check("t4_valid", {31'd0, out_valid}, 32'd0);
    check("t4_ovr", {31'd0, overrun}, 32'd0);
    cycles(2);
    rst = 1'b1;
    cs_low = 0;
    for (int i = 0; i < 40; i++) begin
      if (CS !== 1'b1) cs_low++;
      cycles(1);
    end
    check("t4_quiet", 32'(cs_low), 32'd0);

    // Test 5: ignored starts
    res_q.delete();
    pulse_start(4'b0000, 1'b0);
    cycles(10);
    check("t5_empty_mask", {31'd0, busy}, 32'd0);
    pulse_start(4'b0001, 1'b0);
    cycles(30);
    pulse_start(4'b1111, 1'b1);
    check("t5_busy_kept", {31'd0, busy}, 32'd1);
    wait_idle(400, "t5_timeout");
    cycles(3);
    check("t5_nres", 32'(res_q.size()), 32'd1);

`ifdef ADC_RESULT_BANK_EN
    adc_val[0] = 12'h001; adc_val[1] = 12'h7FF; adc_val[2] = 12'h800; adc_val[3] = 12'hFFF;
    pulse_start(4'b1111, 1'b0);
    wait_idle(800, "bank_timeout");
    for (int i = 0; i < 4; i++) begin
      rd_ch = 3'(i); #1;
      check("bank_rd", 32'(rd_data), 32'(adc_val[i]));
    end
    rd_ch = 3'd5; #1;
    check("bank_oob", 32'(rd_data), 32'd0);
`endif

    // Randomized phase
    ready_mode = 2;
    for (int it = 0; it < 25; it++) begin
      for (int i = 0; i < 8; i++) adc_val[i] = 12'($urandom);
      cont = ($urandom_range(0, 3) == 0);
      pulse_start(NUM_CH'($urandom_range(0, 15)), 1'($urandom_range(0, 1)));
      cycles($urandom_range(20, 150));
      if ($urandom_range(0, 1) == 1) pulse_start(NUM_CH'($urandom_range(1, 15)), 1'($urandom_range(0, 1)));
      if (cont) cycles($urandom_range(100, 400));
      cont = 1'b0;
      wait_idle(1500, "rand_timeout");
      cycles($urandom_range(1, 5));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #900000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "watchdog");
  end
endmodule
